// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding-mode encoding and FP32 field geometry.
package fpu_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011
  } rm_t;

  localparam int FP_BIAS   = 127;
  localparam int FP_MANT_W = 23;
  localparam int FP_EXP_W  = 8;

  // Codes 3'b100..3'b111 are not defined and fall back to round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                    input logic lsb, input logic guard, input logic sticky);
    logic r;
    r = 1'b0;
    case (mode)
      RTZ:     r = 1'b0;
      RDN:     r = sign & (guard | sticky);
      RUP:     r = !sign & (guard | sticky);
      default: r = guard & (sticky | lsb);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lzc.sv
// Parametrised leading-zero counter; cnt == W when the input is all zero.
module lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         d,
  output logic [$clog2(W):0]   cnt,
  output logic                 zero
);

  localparam int CW = $clog2(W) + 1;

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) cnt = CW'(W - 1 - i);
    end
  end

  assign zero = ~|d;

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer-to-FP32 converter (sign/abs, normalise, round/pack)
// with valid/ready handshakes and a pass-through tag.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int TAG_W = 5
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x,
  input  logic             is_signed,
  input  logic [2:0]       rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic             inexact,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW  = $clog2(IN_W) + 1;
  localparam int FW  = IN_W - 1;
  // Fraction field is padded so mantissa, guard and at least one sticky bit always exist.
  localparam int NFW = ((IN_W < 26) ? 26 : IN_W) - 1;

  logic v1_reg, v2_reg, v3_reg;
  logic load1, load2, load3;

  // A stage may load when empty or when its contents move on this cycle.
  assign load3     = !v3_reg | out_ready;
  assign load2     = !v2_reg | load3;
  assign load1     = !v1_reg | load2;
  assign in_ready  = rst & load1;
  assign out_valid = v3_reg;

  // ---------------- Stage 1: sign / magnitude ----------------
  logic             s1_sign_next;
  logic [IN_W-1:0]  s1_abs_next;
  logic             s1_sign_reg;
  logic [IN_W-1:0]  s1_abs_reg;
  logic [2:0]       s1_rm_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  assign s1_sign_next = is_signed & x[IN_W-1];
  assign s1_abs_next  = s1_sign_next ? -x : x;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      v1_reg      <= 1'b0;
      s1_sign_reg <= 1'b0;
      s1_abs_reg  <= '0;
      s1_rm_reg   <= '0;
      s1_tag_reg  <= '0;
    end else if (load1) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg <= s1_sign_next;
        s1_abs_reg  <= s1_abs_next;
        s1_rm_reg   <= rm;
        s1_tag_reg  <= in_tag;
      end
    end
  end

  // ---------------- Stage 2: normalise ----------------
  logic [CW-1:0]          lz_cnt;
  logic                   lz_zero;
  logic [FW-1:0]          frac;
  logic [NFW-1:0]         norm;
  logic [FP_EXP_W-1:0]    s2_exp_next;

  lzc #(.W(IN_W)) u_lzc (
    .d    (s1_abs_reg),
    .cnt  (lz_cnt),
    .zero (lz_zero)
  );

  // The leading one is shifted out of the top; only the bits below it remain.
  assign frac        = FW'(s1_abs_reg << lz_cnt);
  assign norm        = NFW'(frac) << (NFW - FW);
  assign s2_exp_next = FP_EXP_W'(FP_BIAS + IN_W - 1) - FP_EXP_W'(lz_cnt);

  logic                 s2_sign_reg, s2_zero_reg, s2_g_reg, s2_t_reg;
  logic [FP_EXP_W-1:0]  s2_exp_reg;
  logic [FP_MANT_W-1:0] s2_mant_reg;
  logic [2:0]           s2_rm_reg;
  logic [TAG_W-1:0]     s2_tag_reg;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      v2_reg      <= 1'b0;
      s2_sign_reg <= 1'b0;
      s2_zero_reg <= 1'b0;
      s2_g_reg    <= 1'b0;
      s2_t_reg    <= 1'b0;
      s2_exp_reg  <= '0;
      s2_mant_reg <= '0;
      s2_rm_reg   <= '0;
      s2_tag_reg  <= '0;
    end else if (load2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_zero_reg <= lz_zero;
        s2_exp_reg  <= s2_exp_next;
        s2_mant_reg <= norm[NFW-1 -: FP_MANT_W];
        s2_g_reg    <= norm[NFW-FP_MANT_W-1];
        s2_t_reg    <= |norm[NFW-FP_MANT_W-2:0];
        s2_rm_reg   <= s1_rm_reg;
        s2_tag_reg  <= s1_tag_reg;
      end
    end
  end

  // ---------------- Stage 3: round / pack ----------------
  logic                 rnd_up;
  logic [FP_MANT_W:0]   mant_sum;
  logic [FP_EXP_W-1:0]  exp_fin;
  logic [31:0]          y_next;
  logic                 inexact_next;

  assign rnd_up   = round_up(s2_rm_reg, s2_sign_reg, s2_mant_reg[0], s2_g_reg, s2_t_reg);
  assign mant_sum = {1'b0, s2_mant_reg} + (FP_MANT_W + 1)'(rnd_up);
  // A carry out of the mantissa leaves the field zero and bumps the exponent.
  assign exp_fin  = s2_exp_reg + FP_EXP_W'(mant_sum[FP_MANT_W]);

  assign y_next       = s2_zero_reg ? 32'h0000_0000
                                    : {s2_sign_reg, exp_fin, mant_sum[FP_MANT_W-1:0]};
  assign inexact_next = !s2_zero_reg & (s2_g_reg | s2_t_reg);

  logic [31:0]      y_reg;
  logic             inexact_reg;
  logic [TAG_W-1:0] out_tag_reg;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      v3_reg      <= 1'b0;
      y_reg       <= '0;
      inexact_reg <= 1'b0;
      out_tag_reg <= '0;
    end else if (load3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        y_reg       <= y_next;
        inexact_reg <= inexact_next;
        out_tag_reg <= s2_tag_reg;
      end
    end
  end

  assign y       = y_reg;
  assign inexact = inexact_reg;
  assign out_tag = out_tag_reg;

endmodule

// File: tb/tb_itof_pipe.sv
// Directed bench for itof_pipe: 32- and 64-bit instances, rounding modes,
// back-pressure ordering and mid-stream reset.
module tb_itof_pipe;
  import fpu_pkg::*;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  logic        iv32, ir32, sg32, ov32, or32, ix32;
  logic [31:0] x32, y32;
  logic [2:0]  rm32;
  logic [4:0]  it32, ot32;

  logic        iv64, ir64, sg64, ov64, or64, ix64;
  logic [63:0] x64;
  logic [31:0] y64;
  logic [2:0]  rm64;
  logic [4:0]  it64, ot64;

  itof_pipe #(.IN_W(32), .TAG_W(5)) dut32 (
    .sys_clk(sys_clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .x(x32),
    .is_signed(sg32), .rm(rm32), .in_tag(it32), .out_valid(ov32), .out_ready(or32),
    .y(y32), .inexact(ix32), .out_tag(ot32)
  );

  itof_pipe #(.IN_W(64), .TAG_W(5)) dut64 (
    .sys_clk(sys_clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .x(x64),
    .is_signed(sg64), .rm(rm64), .in_tag(it64), .out_valid(ov64), .out_ready(or64),
    .y(y64), .inexact(ix64), .out_tag(ot64)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [4:0] tagn = 5'd0;

  logic [31:0] stream_y [0:7] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                                  32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", nm, obs, exp);
  endtask

  // One isolated conversion; called #1 after a rising edge, returns likewise.
  task automatic conv(input string nm, input bit w64, input logic [63:0] xv, input logic sg,
                      input logic [2:0] rmv, input logic [31:0] ey, input logic ei);
    logic [4:0] tg;
    tg   = tagn;
    tagn = tagn + 5'd1;
    if (w64) begin
      iv64 = 1'b1; x64 = xv; sg64 = sg; rm64 = rmv; it64 = tg; or64 = 1'b1;
    end else begin
      iv32 = 1'b1; x32 = xv[31:0]; sg32 = sg; rm32 = rmv; it32 = tg; or32 = 1'b1;
    end
    #1;
    check({nm, " in_ready"}, w64 ? ir64 : ir32, 1);
    @(posedge sys_clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    check({nm, " valid@+1"}, w64 ? ov64 : ov32, 0);
    @(posedge sys_clk); #1;
    check({nm, " valid@+2"}, w64 ? ov64 : ov32, 0);
    @(posedge sys_clk); #1;
    check({nm, " valid@+3"}, w64 ? ov64 : ov32, 1);
    check({nm, " y"},        w64 ? y64 : y32, ey);
    check({nm, " inexact"},  w64 ? ix64 : ix32, ei);
    check({nm, " tag"},      w64 ? ot64 : ot32, tg);
    @(posedge sys_clk); #1;
    check({nm, " drained"},  w64 ? ov64 : ov32, 0);
  endtask

  initial begin
    int sent, recv;
    rst = 1'b0;
    iv32 = 0; x32 = 0; sg32 = 0; rm32 = RNE; it32 = 0; or32 = 1;
    iv64 = 0; x64 = 0; sg64 = 0; rm64 = RNE; it64 = 0; or64 = 1;

    @(posedge sys_clk); #1;
    check("rst out_valid", ov32, 0);
    check("rst y",         y32, 0);
    check("rst inexact",   ix32, 0);
    check("rst out_tag",   ot32, 0);
    check("rst in_ready",  ir32, 0);
    check("rst in_ready64", ir64, 0);
    @(posedge sys_clk); #1;
    rst = 1'b1;

    conv("one",        0, 64'h1,         1, RNE,    32'h3F80_0000, 0);
    conv("zero",       0, 64'h0,         1, RNE,    32'h0000_0000, 0);
    conv("zero_rup",   0, 64'h0,         1, RUP,    32'h0000_0000, 0);
    conv("intmin",     0, 64'h8000_0000, 1, RNE,    32'hCF00_0000, 0);
    conv("neg1",       0, 64'hFFFF_FFFF, 1, RNE,    32'hBF80_0000, 0);
    conv("umax_rne",   0, 64'hFFFF_FFFF, 0, RNE,    32'h4F80_0000, 1);
    conv("umax_rtz",   0, 64'hFFFF_FFFF, 0, RTZ,    32'h4F7F_FFFF, 1);
    conv("tie_rne",    0, 64'h0100_0001, 1, RNE,    32'h4B80_0000, 1);
    conv("tie_rup",    0, 64'h0100_0001, 1, RUP,    32'h4B80_0001, 1);
    conv("neg_rdn",    0, 64'hFEFF_FFFF, 1, RDN,    32'hCB80_0001, 1);
    conv("neg_rup",    0, 64'hFEFF_FFFF, 1, RUP,    32'hCB80_0000, 1);
    conv("odd_rm5",    0, 64'h0100_0003, 1, 3'b101, 32'h4B80_0002, 1);
    conv("odd_rtz",    0, 64'h0100_0003, 1, RTZ,    32'h4B80_0001, 1);
    conv("w64_neg1",   1, 64'hFFFF_FFFF_FFFF_FFFF, 1, RNE, 32'hBF80_0000, 0);
    conv("w64_msb",    1, 64'h8000_0000_0000_0000, 0, RNE, 32'h5F00_0000, 0);
    conv("w64_sticky", 1, 64'h0000_0000_0100_0001, 0, RNE, 32'h4B80_0000, 1);

    // Back-pressure: 8 ops tagged 0..7, consumer stalls during cycles 4..9.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      or32 = !(cyc >= 4 && cyc <= 9);
      iv32 = (sent < 8);
      x32  = 32'(sent + 1); it32 = 5'(sent); sg32 = 1'b1; rm32 = RNE;
      #1;
      if (sent < 8) check("bp in_ready", ir32, !(cyc >= 4 && cyc <= 9));
      if (cyc >= 4 && cyc <= 9) begin
        check("bp stall valid", ov32, 1);
        check("bp stall y",     y32, stream_y[recv]);
        check("bp stall tag",   ot32, 5'(recv));
      end
      if (ov32 && or32) begin
        if (recv < 8) begin
          check("bp y",   y32, stream_y[recv]);
          check("bp tag", ot32, 5'(recv));
          recv++;
        end else begin
          check("bp extra", ov32, 0);
        end
      end
      if (iv32 && ir32) sent++;
      @(posedge sys_clk); #1;
    end
    iv32 = 1'b0;
    check("bp sent", sent, 8);
    check("bp recv", recv, 8);
    check("bp idle", ov32, 0);

    // Reset with three ops held.
    or32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv32 = 1'b1; x32 = 32'(5 + i); it32 = 5'(20 + i); sg32 = 1'b0; rm32 = RNE;
      @(posedge sys_clk); #1;
    end
    iv32 = 1'b0;
    check("pre-rst valid", ov32, 1);
    check("pre-rst y",     y32, 32'h40A0_0000);
    check("pre-rst tag",   ot32, 20);
    rst = 1'b0;
    #1;
    check("mid-rst valid",    ov32, 0);
    check("mid-rst y",        y32, 0);
    check("mid-rst inexact",  ix32, 0);
    check("mid-rst tag",      ot32, 0);
    check("mid-rst in_ready", ir32, 0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    rst = 1'b1;
    or32 = 1'b1;
    check("post-rst no stale", ov32, 0);
    conv("post-rst two", 0, 64'h2, 1, RNE, 32'h4000_0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
